// File: rtl/bank_out_net_pkg.sv
// rtl/bank_out_net_pkg.sv - shared constants, lane-select types and permutation helper for bank_out_net
package bank_out_net_pkg;

  localparam int NUM_BANKS  = 4;
  localparam int SEL_W      = 2;
  localparam int DEF_DW     = 24;
  localparam int DEF_RD_LAT = 2;

  // One lane index, as carried on each per-bank select
  typedef logic [SEL_W-1:0] lane_sel_t;

  // One select-pipeline word: the read's valid plus the four per-bank selects
  typedef struct packed {
    logic                            valid;
    lane_sel_t [NUM_BANKS-1:0]       sel;
  } sel_word_t;

  localparam int SEL_WORD_W = 1 + NUM_BANKS * SEL_W;

  // A select set is a permutation exactly when every lane is named by some bank
  function automatic logic is_perm(input lane_sel_t [NUM_BANKS-1:0] sel);
    logic [NUM_BANKS-1:0] seen;
    seen = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      seen[sel[k]] = 1'b1;
    end
    return &seen;
  endfunction

endpackage

// File: rtl/bank_out_net_if.sv
// rtl/bank_out_net_if.sv - select/bank-data/lane-data bundle between the bank array and bank_out_net
interface bank_out_net_if #(
  parameter int DW = bank_out_net_pkg::DEF_DW
);
  import bank_out_net_pkg::*;

  lane_sel_t         sel_a_0;
  lane_sel_t         sel_a_1;
  lane_sel_t         sel_a_2;
  lane_sel_t         sel_a_3;
  logic              in_valid;
  logic [DW-1:0]     q0;
  logic [DW-1:0]     q1;
  logic [DW-1:0]     q2;
  logic [DW-1:0]     q3;
  logic [DW-1:0]     d0;
  logic [DW-1:0]     d1;
  logic [DW-1:0]     d2;
  logic [DW-1:0]     d3;
  logic              out_valid;
  logic              perm_err;

  // Side that issues selects and supplies bank read data
  modport master (
    output sel_a_0, sel_a_1, sel_a_2, sel_a_3, in_valid,
    output q0, q1, q2, q3,
    input  d0, d1, d2, d3, out_valid, perm_err
  );

  // The output network itself
  modport slave (
    input  sel_a_0, sel_a_1, sel_a_2, sel_a_3, in_valid,
    input  q0, q1, q2, q3,
    output d0, d1, d2, d3, out_valid, perm_err
  );

endinterface

// File: rtl/bank_out_net_dff.sv
// rtl/bank_out_net_dff.sv - parameterised enable DFF cell with asynchronous active-high clear
module dff_cell #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear immediately on reset, otherwise load when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bank_out_net_sel_delay_line.sv
// rtl/bank_out_net_sel_delay_line.sv - fixed-depth, no-stall shift register built from dff_cell stages
module sel_delay_line #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH+1];

  assign stage[0] = din;

  // Every stage advances every cycle so the selects stay in lockstep with bank latency
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    dff_cell #(.W(W)) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .d   (stage[i]),
      .q   (stage[i+1])
    );
  end

  assign dout = stage[DEPTH];

endmodule

// File: rtl/bank_out_net.sv
// rtl/bank_out_net.sv - bank-to-lane inverse read-data router; BANK_OUT_PERM_CHECK_EN adds sticky perm_err
module bank_out_net
  import bank_out_net_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic          clk,
  input  logic          rst,
  bank_out_net_if.slave bus
);

  sel_word_t                        sel_in;
  sel_word_t                        sel_dly;
  logic [NUM_BANKS-1:0][DW-1:0]     q_bank;
  logic [NUM_BANKS-1:0][DW-1:0]     route_d;
  logic [NUM_BANKS-1:0][DW-1:0]     d_reg;

  assign sel_in = {bus.in_valid, bus.sel_a_3, bus.sel_a_2, bus.sel_a_1, bus.sel_a_0};
  assign q_bank = {bus.q3, bus.q2, bus.q1, bus.q0};

  // Delay the selects by the bank read latency so they meet their own q data
  sel_delay_line #(
    .DEPTH (RD_LAT),
    .W     (SEL_WORD_W)
  ) u_sel_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (sel_in),
    .dout (sel_dly)
  );

  // Inverse routing: lane sel_k takes q_k; scanning banks high to low lets bank 0 win ties,
  // and a lane no bank names stays 0
  always_comb begin
    route_d = '0;
    for (int j = 0; j < NUM_BANKS; j++) begin
      for (int k = NUM_BANKS - 1; k >= 0; k--) begin
        if (sel_dly.sel[k] == lane_sel_t'(j)) begin
          route_d[j] = q_bank[k];
        end
      end
    end
  end

  // Lane data registers load only for a completed read and otherwise hold
  dff_cell #(.W(NUM_BANKS * DW)) u_d_reg (
    .clk (clk),
    .rst (rst),
    .en  (sel_dly.valid),
    .d   (route_d),
    .q   (d_reg)
  );

  // out_valid follows the delayed valid one cycle later, alongside the lane data
  dff_cell #(.W(1)) u_ov_reg (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (sel_dly.valid),
    .q   (bus.out_valid)
  );

  assign bus.d0 = d_reg[0];
  assign bus.d1 = d_reg[1];
  assign bus.d2 = d_reg[2];
  assign bus.d3 = d_reg[3];

`ifdef BANK_OUT_PERM_CHECK_EN
  logic perm_bad;

  assign perm_bad = sel_dly.valid & ~is_perm(sel_dly.sel);

  // Sticky error: set on the first valid non-permutation, cleared only by reset
  dff_cell #(.W(1)) u_perm_reg (
    .clk (clk),
    .rst (rst),
    .en  (perm_bad),
    .d   (1'b1),
    .q   (bus.perm_err)
  );
`else
  assign bus.perm_err = 1'b0;
`endif

endmodule

// File: tb/tb_bank_out_net.sv
// tb/tb_bank_out_net.sv - directed self-checking bench for bank_out_net across RD_LAT 1..4
module tb_bank_out_net;
  import bank_out_net_pkg::*;

  localparam int DW = 24;
`ifdef BANK_OUT_PERM_CHECK_EN
  localparam logic PC = 1'b1;
`else
  localparam logic PC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [3:0][1:0]    sel_s;
  logic [3:0][DW-1:0] q_s;
  logic [3:0][DW-1:0] qp [5];

  logic [3:0][3:0][DW-1:0] dout;
  logic [3:0]              ov;
  logic [3:0]              pe;

  int total_n = 0;
  int pass_n  = 0;
  int fail_n  = 0;

  logic [3:0][1:0]    st_sel [8];
  logic [3:0][1:0]    st_inv [8];

  always #5 clk = ~clk;

  // Bank model: read data issued alongside in_valid comes back after L cycles at qp[L]
  always @(posedge clk) begin
    qp[1] <= q_s;
    for (int k = 2; k < 5; k++) qp[k] <= qp[k-1];
  end

  for (genvar g = 0; g < 4; g++) begin : g_lat
    bank_out_net_if #(.DW(DW)) bus ();
    assign bus.sel_a_0  = sel_s[0];
    assign bus.sel_a_1  = sel_s[1];
    assign bus.sel_a_2  = sel_s[2];
    assign bus.sel_a_3  = sel_s[3];
    assign bus.in_valid = in_valid;
    assign bus.q0       = qp[g+1][0];
    assign bus.q1       = qp[g+1][1];
    assign bus.q2       = qp[g+1][2];
    assign bus.q3       = qp[g+1][3];
    assign dout[g]      = {bus.d3, bus.d2, bus.d1, bus.d0};
    assign ov[g]        = bus.out_valid;
    assign pe[g]        = bus.perm_err;

    bank_out_net #(.DW(DW), .RD_LAT(g + 1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][1:0] pk_sel(input int a0, input int a1, input int a2, input int a3);
    return {2'(a3), 2'(a2), 2'(a1), 2'(a0)};
  endfunction

  function automatic logic [3:0][DW-1:0] pk_q(input int a0, input int a1, input int a2, input int a3);
    return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  task automatic drive(input logic v, input logic [3:0][1:0] s, input logic [3:0][DW-1:0] q);
    in_valid = v;
    sel_s    = s;
    q_s      = q;
  endtask

  initial begin
    logic [3:0][DW-1:0] id_q;
    logic [3:0][DW-1:0] exp_d;
    int base;

    // Streaming vectors: selects and hand-derived inverse (lane j is served by bank inv[j])
    st_sel[0] = pk_sel(0, 1, 2, 3); st_inv[0] = pk_sel(0, 1, 2, 3);
    st_sel[1] = pk_sel(3, 2, 1, 0); st_inv[1] = pk_sel(3, 2, 1, 0);
    st_sel[2] = pk_sel(1, 0, 3, 2); st_inv[2] = pk_sel(1, 0, 3, 2);
    st_sel[3] = pk_sel(2, 3, 0, 1); st_inv[3] = pk_sel(2, 3, 0, 1);
    st_sel[4] = pk_sel(1, 2, 3, 0); st_inv[4] = pk_sel(3, 0, 1, 2);
    st_sel[5] = pk_sel(3, 0, 1, 2); st_inv[5] = pk_sel(1, 2, 3, 0);
    st_sel[6] = pk_sel(0, 2, 1, 3); st_inv[6] = pk_sel(0, 2, 1, 3);
    st_sel[7] = pk_sel(2, 0, 3, 1); st_inv[7] = pk_sel(1, 3, 0, 2);

    id_q = pk_q(24'hA0A0A0, 24'hB1B1B1, 24'hC2C2C2, 24'hD3D3D3);

    rst = 1'b1;
    drive(1'b0, '0, '0);
    #2;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("reset_d_L%0d", g + 1), dout[g], '0);
      chk($sformatf("reset_ov_L%0d", g + 1), ov[g], 1'b0);
      chk($sformatf("reset_pe_L%0d", g + 1), pe[g], 1'b0);
    end
    step();
    step();
    rst = 1'b0;

    // Identity read and latency sweep: out_valid exactly RD_LAT+1 edges after issue
    drive(1'b1, pk_sel(0, 1, 2, 3), id_q);
    for (int n = 1; n <= 5; n++) begin
      step();
      if (n == 1) in_valid = 1'b0;
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("lat_ov_L%0d_e%0d", g + 1, n), ov[g], (n == g + 2) ? 1'b1 : 1'b0);
        if (n == g + 2) chk($sformatf("ident_d_L%0d", g + 1), dout[g], id_q);
      end
    end
    chk("hold_d", dout[1], id_q);
    chk("hold_ov", ov[1], 1'b0);

    // Rotation
    drive(1'b1, pk_sel(1, 2, 3, 0), pk_q(10, 11, 12, 13));
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("rot_ov", ov[1], 1'b1);
    chk("rot_d", dout[1], pk_q(13, 10, 11, 12));
    chk("rot_pe", pe[1], 1'b0);

    // Non-permutation: bank 0 beats bank 1 for lane 2, lane 3 unnamed
    drive(1'b1, pk_sel(2, 2, 0, 1), pk_q(5, 6, 7, 8));
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("bad_ov", ov[1], 1'b1);
    chk("bad_d", dout[1], pk_q(7, 8, 5, 0));
    chk("bad_pe", pe[1], PC);
    step();
    chk("bad_pe_sticky", pe[1], PC);
    chk("bad_ov_drop", ov[1], 1'b0);

    // Streaming: eight back-to-back reads, each result against its own select set
    for (int m = 0; m < 10; m++) begin
      if (m < 8) drive(1'b1, st_sel[m], pk_q((m+1)*16, (m+1)*16 + 1, (m+1)*16 + 2, (m+1)*16 + 3));
      else in_valid = 1'b0;
      step();
      if (m >= 2) begin
        base  = (m - 1) * 16;
        exp_d = pk_q(base + int'(st_inv[m-2][0]), base + int'(st_inv[m-2][1]),
                     base + int'(st_inv[m-2][2]), base + int'(st_inv[m-2][3]));
        chk($sformatf("stream_ov_%0d", m - 2), ov[1], 1'b1);
        chk($sformatf("stream_d_%0d", m - 2), dout[1], exp_d);
        chk($sformatf("stream_pe_%0d", m - 2), pe[1], PC);
      end
    end
    step();
    chk("stream_end_ov", ov[1], 1'b0);

    // Reset mid-flight: in-flight read must never emerge
    for (int w = 0; w < 4; w++) step();
    drive(1'b1, pk_sel(0, 1, 2, 3), id_q);
    step();
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_d", dout[1], '0);
    chk("midrst_ov", ov[1], 1'b0);
    chk("midrst_pe", pe[1], 1'b0);
    step();
    rst = 1'b0;
    for (int n = 3; n <= 6; n++) begin
      step();
      chk($sformatf("midrst_no_ov_e%0d", n), ov, 4'b0000);
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
